dmrf_sequencer: RTL and testbench

Multi-cycle control sequencer for the FullDMRFALU datapath (register file, ALU, data memory). It accepts one 32-bit MIPS-style instruction at a time over a valid/ready handshake and decodes it. It then steps the datapath through EXEC/MEM/WB states, driving every datapath control and field input, and pulses `done` when the instruction retires.

---
 rtl/dmrf_sequencer.sv | 169 ++++++++++++++++
 tb/tb_dmrf_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/dmrf_sequencer.sv
// Multi-cycle control sequencer for the FullDMRFALU datapath: accepts one
// instruction at a time, then walks EXEC/MEM/WB with fully registered controls.
module dmrf_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic             Zero,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [15:0]      SEin,
  output logic [3:0]       FuncCode,
  output logic             Regsel,
  output logic             ALUsel,
  output logic [1:0]       ALUOp,
  output logic             MemWrite,
  output logic             MemRead,
  output logic             MemToRegSel,
  output logic             RegWrite,
  output logic             done,
  output logic             branch_taken,
  output logic             err,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_e;
  typedef enum logic [2:0] {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_ILL} op_e;

  state_e           state_q;
  op_e              op_q, op_d;
  logic [4:0]       rs_q, rt_q, rd_q;
  logic [15:0]      sein_q;
  logic [3:0]       func_q;
  logic             regsel_q, alusel_q, m2r_q;
  logic [1:0]       aluop_q;
  logic             regsel_d, alusel_d, m2r_d;
  logic [1:0]       aluop_d;
  logic             mw_q, mr_q, rw_q, done_q, bt_q, err_q;
  logic [CNT_W-1:0] cnt_q;

  // Shamt/upper function bits are not used by this datapath.
  logic unused_bits;
  assign unused_bits = ^instr[10:4];

  always_comb begin
    op_d     = OP_ILL;
    regsel_d = 1'b0;
    alusel_d = 1'b0;
    aluop_d  = 2'b00;
    m2r_d    = 1'b0;
    case (instr[31:26])
      6'b000000: begin op_d = OP_R;    regsel_d = 1'b1; aluop_d = 2'b10; end
      6'b001000: begin op_d = OP_ADDI; alusel_d = 1'b1; end
      6'b100011: begin op_d = OP_LW;   alusel_d = 1'b1; m2r_d = 1'b1; end
      6'b101011: begin op_d = OP_SW;   alusel_d = 1'b1; end
      6'b000100: begin op_d = OP_BEQ;  aluop_d  = 2'b01; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_ILL;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      sein_q   <= '0;
      func_q   <= '0;
      regsel_q <= 1'b0;
      alusel_q <= 1'b0;
      aluop_q  <= 2'b00;
      m2r_q    <= 1'b0;
      mw_q     <= 1'b0;
      mr_q     <= 1'b0;
      rw_q     <= 1'b0;
      done_q   <= 1'b0;
      bt_q     <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (instr_valid) begin
          state_q  <= EXEC;
          op_q     <= op_d;
          rs_q     <= instr[25:21];
          rt_q     <= instr[20:16];
          rd_q     <= instr[15:11];
          sein_q   <= instr[15:0];
          func_q   <= instr[3:0];
          regsel_q <= regsel_d;
          alusel_q <= alusel_d;
          aluop_q  <= aluop_d;
          m2r_q    <= m2r_d;
          done_q   <= (op_d == OP_BEQ) || (op_d == OP_ILL);
          err_q    <= (op_d == OP_ILL);
          // Zero is captured at acceptance so branch_taken stays registered
          // yet lines up with the single-cycle BEQ done pulse.
          bt_q     <= (op_d == OP_BEQ) && Zero;
        end
        EXEC: case (op_q)
          OP_R, OP_ADDI: begin state_q <= WB;  rw_q <= 1'b1; done_q <= 1'b1; end
          OP_LW:         begin state_q <= MEM; mr_q <= 1'b1; end
          OP_SW:         begin state_q <= MEM; mw_q <= 1'b1; done_q <= 1'b1; end
          default: begin
            state_q  <= IDLE;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            bt_q     <= 1'b0;
            regsel_q <= 1'b0;
            alusel_q <= 1'b0;
            aluop_q  <= 2'b00;
            m2r_q    <= 1'b0;
            if (op_q == OP_BEQ) cnt_q <= cnt_q + CNT_W'(1);
          end
        endcase
        MEM: if (op_q == OP_LW) begin
          state_q <= WB;
          rw_q    <= 1'b1;
          done_q  <= 1'b1;
        end else begin
          state_q  <= IDLE;
          mw_q     <= 1'b0;
          done_q   <= 1'b0;
          regsel_q <= 1'b0;
          alusel_q <= 1'b0;
          aluop_q  <= 2'b00;
          m2r_q    <= 1'b0;
          cnt_q    <= cnt_q + CNT_W'(1);
        end
        WB: begin
          state_q  <= IDLE;
          rw_q     <= 1'b0;
          mr_q     <= 1'b0;
          done_q   <= 1'b0;
          regsel_q <= 1'b0;
          alusel_q <= 1'b0;
          aluop_q  <= 2'b00;
          m2r_q    <= 1'b0;
          cnt_q    <= cnt_q + CNT_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instr_ready  = (state_q == IDLE);
  assign rs           = rs_q;
  assign rt           = rt_q;
  assign rd           = rd_q;
  assign SEin         = sein_q;
  assign FuncCode     = func_q;
  assign Regsel       = regsel_q;
  assign ALUsel       = alusel_q;
  assign ALUOp        = aluop_q;
  assign MemToRegSel  = m2r_q;
  assign MemWrite     = mw_q;
  assign MemRead      = mr_q;
  assign RegWrite     = rw_q;
  assign done         = done_q;
  assign branch_taken = bt_q;
  assign err          = err_q;
  assign instr_count  = cnt_q;

endmodule

// File: tb/tb_dmrf_sequencer.sv
// Scoreboard bench for dmrf_sequencer; a narrow-counter twin shares the inputs
// so counter wrap is reachable in a short run.
module tb_dmrf_sequencer;
  logic        gclk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid, Zero;
  logic        instr_ready, Regsel, ALUsel, MemWrite, MemRead, MemToRegSel;
  logic        RegWrite, done, branch_taken, err;
  logic [4:0]  rs, rt, rd;
  logic [15:0] SEin;
  logic [3:0]  FuncCode;
  logic [1:0]  ALUOp;
  logic [15:0] instr_count;
  logic        w_ready, w_regsel, w_alusel, w_mw, w_mr, w_m2r, w_rw, w_done, w_bt, w_err;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [15:0] w_sein;
  logic [3:0]  w_func;
  logic [1:0]  w_aluop;
  logic [2:0]  w_count;

  always #5 gclk = ~gclk;

  dmrf_sequencer dut (
    .clk(gclk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .Zero(Zero), .rs(rs), .rt(rt), .rd(rd),
    .SEin(SEin), .FuncCode(FuncCode), .Regsel(Regsel), .ALUsel(ALUsel),
    .ALUOp(ALUOp), .MemWrite(MemWrite), .MemRead(MemRead),
    .MemToRegSel(MemToRegSel), .RegWrite(RegWrite), .done(done),
    .branch_taken(branch_taken), .err(err), .instr_count(instr_count));

  dmrf_sequencer #(.CNT_W(3)) dut_w (
    .clk(gclk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(w_ready), .Zero(Zero), .rs(w_rs), .rt(w_rt), .rd(w_rd),
    .SEin(w_sein), .FuncCode(w_func), .Regsel(w_regsel), .ALUsel(w_alusel),
    .ALUOp(w_aluop), .MemWrite(w_mw), .MemRead(w_mr),
    .MemToRegSel(w_m2r), .RegWrite(w_rw), .done(w_done),
    .branch_taken(w_bt), .err(w_err), .instr_count(w_count));

  typedef struct {
    int         lat, nrw, nmw, nmr;
    logic       regsel, alusel, m2r, bt, er, legal;
    logic [1:0] aluop;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] ins, input logic z);
    exp_t e;
    e = '{lat: 1, nrw: 0, nmw: 0, nmr: 0, regsel: 1'b0, alusel: 1'b0, m2r: 1'b0,
          bt: 1'b0, er: 1'b0, legal: 1'b1, aluop: 2'b00};
    case (ins[31:26])
      6'h00: begin e.lat = 2; e.nrw = 1; e.regsel = 1'b1; e.aluop = 2'b10; end
      6'h08: begin e.lat = 2; e.nrw = 1; e.alusel = 1'b1; end
      6'h23: begin e.lat = 3; e.nrw = 1; e.nmr = 2; e.alusel = 1'b1; e.m2r = 1'b1; end
      6'h2B: begin e.lat = 2; e.nmw = 1; e.alusel = 1'b1; end
      6'h04: begin e.aluop = 2'b01; e.bt = z; end
      default: begin e.er = 1'b1; e.legal = 1'b0; end
    endcase
    return e;
  endfunction

  // Issues one instruction from an IDLE negedge and follows it back to IDLE.
  task automatic issue(input logic [31:0] ins, input logic z, input bit hold);
    exp_t e, got;
    int   nrw = 0, nmw = 0, nmr = 0;
    bit   seen = 0, idle = 0;
    e = model(ins, z);
    sbq.push_back(e);
    instr = ins; instr_valid = 1'b1; Zero = z;
    @(negedge gclk);
    if (hold) instr = 32'hFC000000;
    else instr_valid = 1'b0;
    chk("ready_busy", 32'(instr_ready), 32'd0);
    chk("fields", 32'({rs, rt, rd, SEin}), 32'({ins[25:21], ins[20:16], ins[15:11], ins[15:0]}));
    chk("funccode", 32'(FuncCode), 32'(ins[3:0]));
    chk("sel_exec", 32'({Regsel, ALUsel, ALUOp, MemToRegSel}),
        32'({sbq[0].regsel, sbq[0].alusel, sbq[0].aluop, sbq[0].m2r}));
    for (int c = 1; c <= 8 && !idle; c++) begin
      if (instr_ready) idle = 1;
      else begin
        nrw += int'(RegWrite); nmw += int'(MemWrite); nmr += int'(MemRead);
        if (done) begin
          if (sbq.size() == 0) chk("sb_empty", 32'd1, 32'd0);
          else begin
            got = sbq.pop_front();
            seen = 1;
            chk("latency", 32'(c), 32'(got.lat));
            chk("branch_taken", 32'(branch_taken), 32'(got.bt));
            chk("err", 32'(err), 32'(got.er));
          end
          if (hold) instr_valid = 1'b0;
        end
        @(negedge gclk);
      end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    if (!idle) chk("idle_timeout", 32'd0, 32'd1);
    instr_valid = 1'b0;
    if (e.legal) exp_cnt++;
    chk("regwrite_cycles", 32'(nrw), 32'(e.nrw));
    chk("memwrite_cycles", 32'(nmw), 32'(e.nmw));
    chk("memread_cycles", 32'(nmr), 32'(e.nmr));
    chk("sel_idle", 32'({Regsel, ALUsel, ALUOp, MemToRegSel, done, err, branch_taken}), 32'd0);
    chk("instr_count", 32'(instr_count), 32'(exp_cnt & 16'hFFFF));
    chk("count_wrap", 32'(w_count), 32'(exp_cnt % 8));
  endtask

  initial begin
    rst_n = 1'b0; instr = '0; instr_valid = 1'b0; Zero = 1'b0;
    @(negedge gclk);
    chk("rst_fields", 32'({rs, rt, rd, SEin}), 32'd0);
    chk("rst_ctl", 32'({FuncCode, Regsel, ALUsel, ALUOp, MemWrite, MemRead, MemToRegSel,
                        RegWrite, done, branch_taken, err}), 32'd0);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_count", 32'(instr_count), 32'd0);
    @(negedge gclk);
    rst_n = 1'b1;
    @(negedge gclk);

    issue(32'h20050014, 1'b0, 0);
    issue(32'h00A55020, 1'b0, 0);
    issue(32'h8C030014, 1'b0, 0);
    issue(32'hAC050008, 1'b0, 0);
    issue(32'h10A50003, 1'b1, 0);
    issue(32'h10A50003, 1'b0, 0);
    issue(32'hFC000000, 1'b0, 0);
    issue(32'h8C030014, 1'b1, 1);
    issue(32'h00A55020, 1'b0, 1);

    // Reset asserted while LW sits in MEM.
    instr = 32'h8C030014; instr_valid = 1'b1;
    @(negedge gclk);
    instr_valid = 1'b0;
    @(negedge gclk);
    chk("lw_mem_read", 32'(MemRead), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_fields", 32'({rs, rt, rd, SEin}), 32'd0);
    chk("midrst_ctl", 32'({FuncCode, Regsel, ALUsel, ALUOp, MemWrite, MemRead, MemToRegSel,
                           RegWrite, done, branch_taken, err}), 32'd0);
    chk("midrst_ready", 32'(instr_ready), 32'd1);
    chk("midrst_count", 32'(instr_count), 32'd0);
    exp_cnt = 0;
    @(negedge gclk);
    rst_n = 1'b1;
    @(negedge gclk);
    chk("post_rst_count", 32'(instr_count), 32'd0);

    for (int i = 0; i < 9; i++) issue(32'h10A50003, 1'(i % 2), 0);
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
